// File: rtl/video_frame_capture_core.sv
// Video stream tap: forwards pixels through one register stage and, on CPU
// request, captures one window of a frame into a RAM readable over Avalon-MM.
package vga_pkg;
  typedef struct packed {
    logic        frame_start;
    logic [10:0] vc;
    logic [10:0] hc;
  } vga_fc_t;
endpackage

module video_frame_capture_core
  import vga_pkg::*;
#(
  parameter int RGB_SIZE   = 12,
  parameter int X_ORIGIN   = 0,
  parameter int Y_ORIGIN   = 0,
  parameter int WIN_H      = 32,
  parameter int WIN_V      = 32,
  parameter int CAP_RAM_AW = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [CAP_RAM_AW:0]   avs_address,
  input  logic                  avs_read,
  output logic [31:0]           avs_readdata,
  input  logic                  avs_write,
  input  logic [31:0]           avs_writedata,
  input  vga_fc_t               src_fc,
  input  logic                  src_vld,
  input  logic [RGB_SIZE-1:0]   src_rgb,
  output logic                  src_rdy,
  output vga_fc_t               snk_fc,
  output logic                  snk_vld,
  output logic [RGB_SIZE-1:0]   snk_rgb,
  input  logic                  snk_rdy
);

  localparam int                  WIN_N  = WIN_H * WIN_V;
  localparam logic [CAP_RAM_AW:0] WIN_NP = (CAP_RAM_AW+1)'(WIN_N);
  localparam logic [11:0]         XO = 12'(X_ORIGIN);
  localparam logic [11:0]         YO = 12'(Y_ORIGIN);
  localparam logic [11:0]         WH = 12'(WIN_H);
  localparam logic [11:0]         WV = 12'(WIN_V);

  typedef enum logic [1:0] {S_IDLE, S_ARMED, S_CAPTURE, S_DONE} state_t;

  state_t                r_state;
  logic [CAP_RAM_AW:0]   r_wr_ptr;
  logic                  r_done;
  logic                  r_overrun;
  // Sized to the full address space; reads beyond the window are masked to 0.
  logic [RGB_SIZE-1:0]   r_ram [0:(2**CAP_RAM_AW)-1];

  logic                  w_acc;
  logic                  w_fs;
  logic [11:0]           w_hrel;
  logic [11:0]           w_vrel;
  logic                  w_in_win;
  logic                  w_ctrl_wr;
  logic                  w_abort;
  logic                  w_arm;
  logic                  w_ram_we;
  logic [CAP_RAM_AW:0]   w_ptr_nxt;
  logic                  w_full;
  logic [31:0]           w_status;
  logic                  w_unused;

  assign src_rdy = snk_rdy | ~snk_vld;
  assign w_acc   = src_vld & src_rdy;
  assign w_fs    = src_fc.frame_start;

  // Zero-extended subtraction wraps coordinates left of / above the origin out of range.
  assign w_hrel   = {1'b0, src_fc.hc} - XO;
  assign w_vrel   = {1'b0, src_fc.vc} - YO;
  assign w_in_win = (w_hrel < WH) && (w_vrel < WV);

  assign w_ctrl_wr = avs_write & avs_address[CAP_RAM_AW] & ~avs_address[0];
  assign w_abort   = w_ctrl_wr & avs_writedata[1];
  assign w_arm     = w_ctrl_wr & avs_writedata[0] & ~avs_writedata[1];
  assign w_unused  = &{1'b0, avs_writedata[31:2]};

  assign w_ram_we  = w_acc & w_in_win & ~w_abort &
                     (((r_state == S_ARMED) & w_fs) | ((r_state == S_CAPTURE) & ~w_fs));
  assign w_ptr_nxt = r_wr_ptr + 1'b1;
  assign w_full    = (w_ptr_nxt == WIN_NP);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      snk_vld <= 1'b0;
      snk_rgb <= '0;
      snk_fc  <= '0;
    end else if (w_acc) begin
      snk_vld <= 1'b1;
      snk_rgb <= src_rgb;
      snk_fc  <= src_fc;
    end else if (snk_rdy) begin
      snk_vld <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_wr_ptr  <= '0;
      r_done    <= 1'b0;
      r_overrun <= 1'b0;
    end else if (w_abort) begin
      r_state <= S_IDLE;
    end else begin
      if (w_ram_we) r_wr_ptr <= w_ptr_nxt;
      case (r_state)
        S_IDLE, S_DONE: begin
          if (w_arm) begin
            r_state   <= S_ARMED;
            r_wr_ptr  <= '0;
            r_done    <= 1'b0;
            r_overrun <= 1'b0;
          end
        end
        S_ARMED: begin
          if (w_acc && w_fs) begin
            r_state <= (w_ram_we && w_full) ? S_DONE : S_CAPTURE;
            r_done  <= w_ram_we && w_full;
          end
        end
        S_CAPTURE: begin
          // A new frame before the window filled means the window ran off the frame.
          if (w_acc && w_fs) begin
            r_state   <= S_DONE;
            r_done    <= 1'b1;
            r_overrun <= 1'b1;
          end else if (w_ram_we && w_full) begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_ram_we) r_ram[r_wr_ptr[CAP_RAM_AW-1:0]] <= src_rgb;
  end

  always_comb begin
    w_status                    = '0;
    w_status[0]                 = (r_state == S_ARMED);
    w_status[1]                 = (r_state == S_CAPTURE);
    w_status[2]                 = r_done;
    w_status[3]                 = r_overrun;
    w_status[16 +: CAP_RAM_AW+1] = r_wr_ptr;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      avs_readdata <= '0;
    end else if (avs_read) begin
      if (avs_address[CAP_RAM_AW])
        avs_readdata <= avs_address[0] ? w_status : 32'd0;
      else if ({1'b0, avs_address[CAP_RAM_AW-1:0]} < WIN_NP)
        avs_readdata <= {{(32-RGB_SIZE){1'b0}}, r_ram[avs_address[CAP_RAM_AW-1:0]]};
      else
        avs_readdata <= 32'd0;
    end
  end

endmodule
